gen3_descrambler_32: RTL and testbench

Receive-side Gen3 (128b/130b) per-lane descrambler with a 32-bit datapath. It sits after block alignment / sync-header stripping and before the receive ordered-set and packet decode logic. It regenerates the same keystream as the transmit Gen3 scrambler and XORs it onto data-block words. It passes ordered-set blocks through unscrambled and applies the Gen3 LFSR hold and reload rules for SKP and EIEOS blocks.

---
 rtl/gen3_descrambler_32_if.sv | 66 ++++++
 rtl/gen3_descrambler_32.sv | 190 +++++++++++++++++++
 tb/tb_gen3_descrambler_32.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen3_descrambler_32_if.sv
`default_nettype none
// ============================================================================
// Module   : gen3_descrambler_32_if
// Purpose  : Receive-lane bundle for the Gen3 32-bit descrambler. Carries the
//            lane seed, the seed-reload request, the aligned block stream
//            from the block aligner, and the descrambled stream with its
//            per-block status toward ordered-set / packet decode.
// Revision : 1.0  initial release
// ============================================================================
interface gen3_descrambler_32_if;

   // Lane configuration and seed control
   logic [23:0] seed_value;
   logic        scrambler_reset;

   // Aligned receive stream (sync header already stripped)
   logic        rx_valid;
   logic [31:0] rx_data;
   logic        rx_start_block;
   logic [1:0]  rx_sync_header;

   // Descrambled stream and block status
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_start_block;
   logic [1:0]  out_sync_header;
   logic [1:0]  out_block_type;
   logic        sync_err;
   logic        block_err;

   // Upstream side: block aligner feeding the descrambler, observing results
   modport master (
      output seed_value,
      output scrambler_reset,
      output rx_valid,
      output rx_data,
      output rx_start_block,
      output rx_sync_header,
      input  out_valid,
      input  out_data,
      input  out_start_block,
      input  out_sync_header,
      input  out_block_type,
      input  sync_err,
      input  block_err
   );

   // Descrambler side
   modport slave (
      input  seed_value,
      input  scrambler_reset,
      input  rx_valid,
      input  rx_data,
      input  rx_start_block,
      input  rx_sync_header,
      output out_valid,
      output out_data,
      output out_start_block,
      output out_sync_header,
      output out_block_type,
      output sync_err,
      output block_err
   );

endinterface
`default_nettype wire

// File: rtl/gen3_descrambler_32.sv
`default_nettype none
// ============================================================================
// Module   : gen3_descrambler_32
// Purpose  : Per-lane Gen3 (128b/130b) receive descrambler, 32-bit datapath,
//            4 beats per block. Regenerates the transmit keystream from a
//            23-bit Galois LFSR (x^23+x^21+x^16+x^8+x^5+x^2+1), XORs it onto
//            data blocks, passes ordered sets raw, holds the LFSR across SKP
//            and invalid blocks and reseeds it at the end of an EIEOS.
//            All outputs are registered; latency is one pclk.
// Revision : 1.0  initial release
// ============================================================================
module gen3_descrambler_32 (
   input  wire logic            pclk,
   input  wire logic            reset,
   gen3_descrambler_32_if.slave bus
);

   // Feedback taps of the Galois LFSR (x^21, x^16, x^8, x^5, x^2, x^0);
   // the x^23 term is implicit in the bit shifted out of position 22.
   localparam logic [22:0] c_taps = 23'h210125;

   // Block classification held across the four beats of a block. INVALID
   // reports as ordered set on the output but freezes the LFSR.
   typedef enum logic [2:0] {
      BT_DATA    = 3'd0,
      BT_OS      = 3'd1,
      BT_SKP     = 3'd2,
      BT_EIEOS   = 3'd3,
      BT_INVALID = 3'd4
   } block_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [22:0] r_lfsr;
   logic [1:0]  r_beat_cnt;
   block_t      r_type;

   logic        r_out_valid;
   logic [31:0] r_out_data;
   logic        r_out_start_block;
   logic [1:0]  r_out_sync_header;
   logic [1:0]  r_out_block_type;
   logic        r_sync_err;
   logic        r_block_err;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic [22:0] w_seed;
   logic [22:0] w_lfsr_walk;
   logic [22:0] w_lfsr_adv;
   logic [31:0] w_keystream;
   logic        w_start;
   logic [1:0]  w_beat;
   logic        w_hdr_bad;
   block_t      w_new_type;
   block_t      w_cur_type;
   block_t      w_type_nxt;
   logic [1:0]  w_beat_nxt;
   logic [22:0] w_lfsr_nxt;
   logic [1:0]  w_type_code;
   logic [31:0] w_data_out;
   logic        w_unused;

   // Only the low 23 seed bits are meaningful for a 23-bit register.
   assign w_seed   = bus.seed_value[22:0];
   assign w_unused = bus.seed_value[23];

   // Unroll 32 serial LFSR shifts: keystream bit i is the bit leaving
   // position 22 on shift i, and pairs with rx_data[i].
   always_comb begin
      w_lfsr_walk = r_lfsr;
      w_keystream = 32'd0;
      for (int i = 0; i < 32; i++) begin
         w_keystream[i] = w_lfsr_walk[22];
         w_lfsr_walk    = {w_lfsr_walk[21:0], 1'b0}
                          ^ (w_lfsr_walk[22] ? c_taps : 23'd0);
      end
      w_lfsr_adv = w_lfsr_walk;
   end

   // Classify the block from its sync header and first symbol.
   always_comb begin
      w_hdr_bad  = (bus.rx_sync_header == 2'b00) || (bus.rx_sync_header == 2'b11);
      w_new_type = BT_INVALID;
      if (bus.rx_sync_header == 2'b10) begin
         w_new_type = BT_DATA;
      end else if (bus.rx_sync_header == 2'b01) begin
         if (bus.rx_data[7:0] == 8'hAA) begin
            w_new_type = BT_SKP;
         end else if (bus.rx_data[7:0] == 8'h00) begin
            w_new_type = BT_EIEOS;
         end else begin
            w_new_type = BT_OS;
         end
      end
   end

   // Next-state: beat position, latched block type and LFSR update rules.
   always_comb begin
      w_start    = bus.rx_valid & bus.rx_start_block;
      // A start beat is always beat 0, whatever the counter says.
      w_beat     = w_start ? 2'd0 : r_beat_cnt;
      w_cur_type = w_start ? w_new_type : r_type;
      w_type_nxt = w_cur_type;
      w_beat_nxt = r_beat_cnt;
      w_lfsr_nxt = r_lfsr;

      if (bus.rx_valid) begin
         w_beat_nxt = w_beat + 2'd1;
         case (w_cur_type)
            BT_DATA, BT_OS: w_lfsr_nxt = w_lfsr_adv;
            BT_EIEOS: begin
               // EIEOS reseeds at its last beat so the next block starts fresh.
               if (w_beat == 2'd3) begin
                  w_lfsr_nxt = w_seed;
               end
            end
            default:        w_lfsr_nxt = r_lfsr;
         endcase
      end

      // Explicit reload wins over advance, hold and EIEOS reload.
      if (bus.scrambler_reset) begin
         w_lfsr_nxt = w_seed;
      end
   end

   // Output word and reported type for the current beat.
   always_comb begin
      w_data_out  = (w_cur_type == BT_DATA) ? (bus.rx_data ^ w_keystream) : bus.rx_data;
      w_type_code = 2'b00;
      case (w_cur_type)
         BT_DATA:  w_type_code = 2'b00;
         BT_OS:    w_type_code = 2'b01;
         BT_SKP:   w_type_code = 2'b10;
         BT_EIEOS: w_type_code = 2'b11;
         default:  w_type_code = 2'b01;
      endcase
   end

   // Keystream and block-tracking state register.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_lfsr     <= w_seed;
         r_beat_cnt <= 2'd0;
         r_type     <= BT_DATA;
      end else begin
         r_lfsr     <= w_lfsr_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_type     <= w_type_nxt;
      end
   end

   // Registered outputs; data, type and header hold through idle cycles.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_out_valid       <= 1'b0;
         r_out_data        <= 32'd0;
         r_out_start_block <= 1'b0;
         r_out_sync_header <= 2'b00;
         r_out_block_type  <= 2'b00;
         r_sync_err        <= 1'b0;
         r_block_err       <= 1'b0;
      end else begin
         r_out_valid       <= bus.rx_valid;
         r_out_start_block <= w_start;
         r_sync_err        <= w_start & w_hdr_bad;
         r_block_err       <= w_start & (r_beat_cnt != 2'd0);
         if (bus.rx_valid) begin
            r_out_data       <= w_data_out;
            r_out_block_type <= w_type_code;
            if (w_start) begin
               r_out_sync_header <= bus.rx_sync_header;
            end
         end
      end
   end

   assign bus.out_valid       = r_out_valid;
   assign bus.out_data        = r_out_data;
   assign bus.out_start_block = r_out_start_block;
   assign bus.out_sync_header = r_out_sync_header;
   assign bus.out_block_type  = r_out_block_type;
   assign bus.sync_err        = r_sync_err;
   assign bus.block_err       = r_block_err;

endmodule
`default_nettype wire

// File: tb/tb_gen3_descrambler_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen3_descrambler_32
// Purpose  : Self-checking bench for gen3_descrambler_32. A transmit-side
//            scrambler model produces the wire stream from known plaintext;
//            a receive reference model predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_gen3_descrambler_32;

   localparam logic [23:0] c_seed = 24'h1DBFBC;
   localparam int T_DATA  = 0;
   localparam int T_OS    = 1;
   localparam int T_SKP   = 2;
   localparam int T_EIEOS = 3;
   localparam int T_BAD   = 4;

   logic pclk  = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   // Receive reference model state and expected outputs
   logic [22:0] m_lfsr;
   int          m_cnt;
   int          m_type;
   logic        e_valid, e_start, e_serr, e_berr;
   logic [31:0] e_data;
   logic [1:0]  e_hdr, e_bt;

   // Transmit scrambler model state
   logic [22:0] tx_lfsr;

   gen3_descrambler_32_if bus();

   gen3_descrambler_32 dut (
      .pclk  (pclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Keystream as polynomial arithmetic: each step multiplies the state by x
   // modulo p(x); the coefficient of x^23 before reduction is the key bit.
   function automatic logic [31:0] keystream(input logic [22:0] s_in, output logic [22:0] s_out);
      logic [23:0] p;
      logic [31:0] k;
      p = {1'b0, s_in};
      k = 32'd0;
      for (int i = 0; i < 32; i++) begin
         p    = p << 1;
         k[i] = p[23];
         if (p[23]) p = p ^ 24'hA10125;
      end
      s_out = p[22:0];
      return k;
   endfunction

   function automatic int classify(input logic [1:0] h, input logic [7:0] b0);
      if (h == 2'b10) return T_DATA;
      if (h != 2'b01) return T_BAD;
      if (b0 == 8'hAA) return T_SKP;
      if (b0 == 8'h00) return T_EIEOS;
      return T_OS;
   endfunction

   task automatic model_reset();
      m_lfsr  = c_seed[22:0];
      tx_lfsr = c_seed[22:0];
      m_cnt   = 0;
      m_type  = T_DATA;
      e_valid = 1'b0; e_start = 1'b0; e_serr = 1'b0; e_berr = 1'b0;
      e_data  = 32'd0; e_hdr = 2'b00; e_bt = 2'b00;
   endtask

   // Predict the outputs produced by one input cycle.
   task automatic ref_beat(input logic v, input logic s, input logic [1:0] h,
                           input logic [31:0] d, input logic sr);
      logic [22:0] nxt;
      logic [31:0] k;
      e_valid = v;
      e_start = v & s;
      e_serr  = 1'b0;
      e_berr  = 1'b0;
      if (v) begin
         k = keystream(m_lfsr, nxt);
         if (s) begin
            e_berr = (m_cnt != 0);
            m_cnt  = 0;
            m_type = classify(h, d[7:0]);
            e_hdr  = h;
            e_serr = (m_type == T_BAD);
         end
         e_data = (m_type == T_DATA) ? (d ^ k) : d;
         e_bt   = (m_type == T_BAD) ? 2'b01 : 2'(m_type);
         if (m_type == T_DATA || m_type == T_OS) m_lfsr = nxt;
         else if (m_type == T_EIEOS && m_cnt == 3) m_lfsr = c_seed[22:0];
         m_cnt = (m_cnt + 1) % 4;
      end
      if (sr) m_lfsr = c_seed[22:0];
   endtask

   // Transmit side: scramble one word of a block of the given kind.
   task automatic tx_word(input int ty, input int beat, input logic [31:0] plain,
                          output logic [31:0] txw);
      logic [22:0] nxt;
      logic [31:0] k;
      k   = keystream(tx_lfsr, nxt);
      txw = (ty == T_DATA) ? (plain ^ k) : plain;
      if (ty == T_DATA || ty == T_OS) tx_lfsr = nxt;
      else if (ty == T_EIEOS && beat == 3) tx_lfsr = c_seed[22:0];
   endtask

   task automatic check_outputs();
      check_eq("out_valid",       32'(bus.out_valid),       32'(e_valid));
      check_eq("out_data",        bus.out_data,             e_data);
      check_eq("out_start_block", 32'(bus.out_start_block), 32'(e_start));
      check_eq("out_sync_header", 32'(bus.out_sync_header), 32'(e_hdr));
      check_eq("out_block_type",  32'(bus.out_block_type),  32'(e_bt));
      check_eq("sync_err",        32'(bus.sync_err),        32'(e_serr));
      check_eq("block_err",       32'(bus.block_err),       32'(e_berr));
   endtask

   // Present one cycle of input, then check the registered result.
   task automatic drive(input logic v, input logic s, input logic [1:0] h, input logic [31:0] d,
                        input logic sr, input logic lb, input logic [31:0] plain);
      bus.rx_valid        = v;
      bus.rx_start_block  = s;
      bus.rx_sync_header  = h;
      bus.rx_data         = d;
      bus.scrambler_reset = sr;
      ref_beat(v, s, h, d, sr);
      @(posedge pclk);
      #1;
      check_outputs();
      if (lb) check_eq("loopback_plain", bus.out_data, plain);
      bus.rx_valid        = 1'b0;
      bus.rx_start_block  = 1'b0;
      bus.scrambler_reset = 1'b0;
   endtask

   task automatic send_block(input logic [1:0] hdr, input int ty, input logic [31:0] w [4],
                             input int nbeats, input int gap_pct, input int sr_beat);
      logic [31:0] txw;
      for (int b = 0; b < nbeats; b++) begin
         while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct)
            drive(1'b0, 1'b0, hdr, $urandom, 1'b0, 1'b0, 32'd0);
         tx_word(ty, b, w[b], txw);
         if (b == sr_beat) tx_lfsr = c_seed[22:0];
         drive(1'b1, b == 0, hdr, txw, b == sr_beat, ty == T_DATA, w[b]);
      end
   endtask

   task automatic async_reset_check();
      #2 reset = 1'b1;
      #1;
      check_eq("rst_out_valid",  32'(bus.out_valid),       32'd0);
      check_eq("rst_out_data",   bus.out_data,             32'd0);
      check_eq("rst_out_start",  32'(bus.out_start_block), 32'd0);
      check_eq("rst_out_hdr",    32'(bus.out_sync_header), 32'd0);
      check_eq("rst_out_type",   32'(bus.out_block_type),  32'd0);
      check_eq("rst_sync_err",   32'(bus.sync_err),        32'd0);
      check_eq("rst_block_err",  32'(bus.block_err),       32'd0);
      model_reset();
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      reset = 1'b0;
   endtask

   task automatic rand_words(output logic [31:0] w [4]);
      for (int b = 0; b < 4; b++) w[b] = $urandom;
   endtask

   initial begin
      logic [31:0] w [4];
      logic [31:0] tmp;
      logic [31:0] txw;

      bus.seed_value      = c_seed;
      bus.scrambler_reset = 1'b0;
      bus.rx_valid        = 1'b0;
      bus.rx_data         = 32'd0;
      bus.rx_start_block  = 1'b0;
      bus.rx_sync_header  = 2'b00;
      model_reset();

      // Power-on reset values
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      check_outputs();
      reset = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0);

      // Loopback: eight data blocks of an incrementing pattern
      for (int n = 0; n < 8; n++) begin
         for (int b = 0; b < 4; b++) w[b] = 32'h03020100 + 32'(n * 4 + b);
         send_block(2'b10, T_DATA, w, 4, 0, -1);
      end

      // Reset mid-block; then a stray non-start beat processed as data beat 0,
      // followed by a start that lands on beat 1 (misaligned)
      rand_words(w);
      send_block(2'b10, T_DATA, w, 2, 0, -1);
      async_reset_check();
      tmp = 32'hC0FFEE11;
      tx_word(T_DATA, 0, tmp, txw);
      drive(1'b1, 1'b0, 2'b10, txw, 1'b0, 1'b1, tmp);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // SKP ordered set between data blocks
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);
      tmp  = $urandom;
      w[0] = 32'hAAAAAAAA; w[1] = 32'hAAAAAAAA; w[2] = 32'hAAAAAAAA;
      w[3] = {tmp[31:8], 8'hE1};
      send_block(2'b01, T_SKP, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // EIEOS reseeds the keystream for the next data block
      for (int b = 0; b < 4; b++) w[b] = 32'hFF00FF00;
      send_block(2'b01, T_EIEOS, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // Generic ordered set advances the keystream
      rand_words(w);
      tmp  = w[0];
      w[0] = {tmp[31:8], 8'h1E};
      send_block(2'b01, T_OS, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // Random idle gaps across sixteen data blocks
      for (int n = 0; n < 16; n++) begin
         rand_words(w);
         send_block(2'b10, T_DATA, w, 4, 30, -1);
      end

      // Invalid sync headers 11 and 00 freeze the keystream
      rand_words(w);
      send_block(2'b11, T_BAD, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b00, T_BAD, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // Start on beat 2 abandons the partial block
      rand_words(w);
      send_block(2'b10, T_DATA, w, 2, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // Seed reload mid-block: current word uses the old keystream
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, 1);
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      // Seed reload during an idle cycle
      drive(1'b0, 1'b0, 2'b10, 32'd0, 1'b1, 1'b0, 32'd0);
      tx_lfsr = c_seed[22:0];
      rand_words(w);
      send_block(2'b10, T_DATA, w, 4, 0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
